// File: rtl/flag_pkg.sv
// Shared constants, FSM state encoding and byte-addressing helpers for the flag loader.
package flag_pkg;

    localparam int NUM_CHARS = 64;
    localparam int NUM_WORDS = 8;
    localparam logic [7:0] PAD_CHAR = 8'h00;
    localparam int IDX_W = 7;
    localparam int WORD_W = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EVAL,
        DONE
    } state_t;

    function automatic logic [WORD_W-1:0] word_sel(input logic [IDX_W-1:0] idx);
        return WORD_W'(idx / 8);
    endfunction

    function automatic logic [2:0] lane_sel(input logic [IDX_W-1:0] idx);
        return 3'(idx % 8);
    endfunction

endpackage

// File: rtl/flag_pack_buf.sv
// Byte-addressable 512-bit register file holding the packed flag string.
module flag_pack_buf
    import flag_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [7:0]                 wr_data,
    output logic [NUM_WORDS-1:0][63:0] words
);

    localparam logic [63:0] PAD_WORD = {8{PAD_CHAR}};

    // A clear and a write in the same cycle leave a fresh pad-filled buffer holding only the new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words <= {NUM_WORDS{PAD_WORD}};
        end else begin
            if (clear) begin
                words <= {NUM_WORDS{PAD_WORD}};
            end
            if (wr_en) begin
                words[word_sel(wr_idx)][{lane_sel(wr_idx), 3'b000} +: 8] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/flag_loader.sv
// Serial byte loader: packs flag characters into eight 64-bit words, then samples the checker once.
module flag_loader
    import flag_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic [63:0] char_input_a,
    output logic [63:0] char_input_b,
    output logic [63:0] char_input_c,
    output logic [63:0] char_input_d,
    output logic [63:0] char_input_e,
    output logic [63:0] char_input_f,
    output logic [63:0] char_input_g,
    output logic [63:0] char_input_h,
    input  logic        chk_is_correct,
    output logic        result_valid,
    output logic        result_pass,
    output logic        result_len_err,
    input  logic        result_ack,
    output logic        busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic                       len_err;
    logic                       accept;
    logic                       buf_clear;
    logic                       buf_wr;
    logic [IDX_W-1:0]           buf_idx;
    logic [NUM_WORDS-1:0][63:0] words;

    assign accept    = in_valid & in_ready;
    assign buf_wr    = accept & ~abort;
    assign buf_clear = abort | (accept & (state == IDLE));
    assign buf_idx   = (state == IDLE) ? '0 : idx;

    flag_pack_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (buf_clear),
        .wr_en   (buf_wr),
        .wr_idx  (buf_idx),
        .wr_data (in_data),
        .words   (words)
    );

    assign char_input_a = words[0];
    assign char_input_b = words[1];
    assign char_input_c = words[2];
    assign char_input_d = words[3];
    assign char_input_e = words[4];
    assign char_input_f = words[5];
    assign char_input_g = words[6];
    assign char_input_h = words[7];

    // in_ready and busy are registered alongside the state so they always match it one cycle on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            len_err        <= 1'b0;
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            result_pass    <= 1'b0;
            result_len_err <= 1'b0;
        end else if (abort) begin
            state          <= IDLE;
            idx            <= '0;
            len_err        <= 1'b0;
            in_ready       <= 1'b1;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            result_pass    <= 1'b0;
            result_len_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        idx  <= IDX_W'(1);
                        busy <= 1'b1;
                        if (in_last) begin
                            state    <= EVAL;
                            len_err  <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            state   <= LOAD;
                            len_err <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state    <= EVAL;
                            len_err  <= 1'b0;
                            in_ready <= 1'b0;
                        end else if (in_last) begin
                            state    <= EVAL;
                            len_err  <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end
                end
                EVAL: begin
                    result_valid   <= 1'b1;
                    result_pass    <= chk_is_correct & ~len_err;
                    result_len_err <= len_err;
                    state          <= DONE;
                end
                DONE: begin
                    if (result_ack) begin
                        state          <= IDLE;
                        idx            <= '0;
                        in_ready       <= 1'b1;
                        busy           <= 1'b0;
                        result_valid   <= 1'b0;
                        result_pass    <= 1'b0;
                        result_len_err <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
